// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift/adjust step per clock.
// Converts WIDTH bits in WIDTH+2 cycles (accept, WIDTH steps, load); values above 9999 set overflow.
module bin_to_bcd_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       hex_out_0,
  output logic [3:0]       hex_out_1,
  output logic [3:0]       hex_out_2,
  output logic [3:0]       hex_out_3
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic             ovf_work;
  logic [CNT_W-1:0] cnt;

  // Add-3 on every digit >= 5, applied before the shift in the same step.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bcd       <= '0;
      ovf_work  <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      hex_out_0 <= 4'd0;
      hex_out_1 <= 4'd0;
      hex_out_2 <= 4'd0;
      hex_out_3 <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift    <= bin_in;
            bcd      <= '0;
            ovf_work <= 1'b0;
            cnt      <= CNT_W'(WIDTH);
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          // The bit pushed out of the thousands digit would start a fifth digit,
          // so any such bit means the value is at least 10000.
          bcd      <= {bcd_adj[14:0], shift[WIDTH-1]};
          shift    <= {shift[WIDTH-2:0], 1'b0};
          ovf_work <= ovf_work | bcd_adj[15];
          cnt      <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          hex_out_0 <= bcd[3:0];
          hex_out_1 <= bcd[7:4];
          hex_out_2 <= bcd[11:8];
          hex_out_3 <= bcd[15:12];
          overflow  <= ovf_work;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
